note_buzzer: RTL
================

NOTE_BUZZER -- requirements
Module: note_buzzer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000; system clock frequency in Hz, used to size the half-period counts.
REQ-002 clk  input  1  system clock; all logic on its rising edge; single clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  play enable; 0 forces silence.
REQ-005 music  input  6  note code from the melody sequencer; 0..47 are tones, 48..63 are rests (63 is the canonical rest).
REQ-006 buzzer  output  1  square-wave drive for the piezo.
REQ-007 playing  output  1  high while a tone is being output.

Function
REQ-008 Code k in 0..47 SHALL map to the equal-tempered semitone k above C3: f(k) = 130.8128 * 2^(k/12) Hz (10=A#3, 15=D#4, 17=F4, 19=G4, 20=G#4, 21=A4=440 Hz, 22=A#4, 27=D#5).
REQ-009 Half-period count H(k) SHALL equal round(CLK_HZ / (2*f(k))) - 1, computed at elaboration, not at run time.
REQ-010 The counter width SHALL be ceil(log2(H(0)+1)); this is 18 bits at the default CLK_HZ.
REQ-011 music and en SHALL be registered once (music_q, en_q) before any use.
REQ-012 FSM states: SILENT, TONE.
REQ-013 SILENT: buzzer=0, playing=0, counter=0.
REQ-014 SILENT->TONE when en_q=1 and music_q<=47: on that edge load counter=H(music_q), set buzzer=1, latch cur_note=music_q.
REQ-015 TONE, counter>0: decrement by 1 each clock.
REQ-016 TONE, counter==0, with en_q=1 and music_q<=47: toggle buzzer, reload H(music_q), latch cur_note=music_q; a new pitch takes effect only at a half-period boundary (glitch-free).
REQ-017 TONE, counter==0, with en_q=0 or music_q>=48: if buzzer=1, toggle it to 0 and stay in TONE with counter=H(cur_note) to finish the period; if buzzer=0, go to SILENT.
REQ-018 en_q=0 mid-half-period SHALL NOT truncate the current half-period; silence begins at the next boundary with buzzer=0.
REQ-019 playing SHALL be 1 exactly while in state TONE.
REQ-020 The first buzzer rise SHALL occur on the 2nd rising edge after music/en present a valid tone while SILENT (1 register stage + 1 FSM edge).
REQ-021 Once started, every high and low phase SHALL last exactly H+1 clocks.

Reset
REQ-022 While rst_n=0 at a clk edge: state=SILENT, buzzer=0, playing=0, counter=0, cur_note=63, music_q=63, en_q=0.
REQ-023 Reset asserted mid-tone SHALL force buzzer=0 on that same edge, with no completion of the period.
REQ-024 After release, the first tone SHALL follow REQ-020 timing.

Structure
REQ-025 Package note_pkg SHALL hold NOTE_REST=63, NOTE_MAX=47, the state enum, and the function that computes H(k) from CLK_HZ.
REQ-026 Sub-module tone_rom SHALL hold the 64-entry combinational lookup music->H; entries 48..63 return 0, and its output is used only for codes <=47.
REQ-027 The FSM, counter and output registers SHALL reside in note_buzzer; total RTL size 120-400 lines.

Verification (bench uses CLK_HZ=880_000, so H(21)=999)
REQ-028 Reset: hold rst_n=0 for 5 clocks with music=21, en=1 -> buzzer=0, playing=0 throughout.
REQ-029 Steady tone: music=21, en=1 after reset -> buzzer rises on the 2nd edge, then alternates 1000-clock high and 1000-clock low phases; playing=1.
REQ-030 Pitch change mid-half-period: music switches 21->33 at clock 500 of a high phase -> the high phase still lasts 1000 clocks; the next phase lasts H(33)+1=500 clocks.
REQ-031 Rest: music switches 21->63 during a high phase -> the high phase completes, one full 1000-clock low phase follows, then playing=0 and buzzer stays 0.
REQ-032 Disable during low phase: en drops at clock 300 of a low phase -> buzzer stays 0, and the FSM enters SILENT at the end of the 1000-clock phase.
REQ-033 Reset mid-tone: rst_n=0 at clock 400 of a high phase -> buzzer=0 on that edge; after release, tone restarts per REQ-020.

Source files
------------

// File: rtl/note_pkg.sv
// Shared constants, FSM state type and the elaboration-time half-period math
// for the note buzzer.
package note_pkg;

   localparam logic [5:0] NOTE_REST = 6'd63;
   localparam logic [5:0] NOTE_MAX  = 6'd47;

   typedef enum logic {SILENT, TONE} state_t;

   // Semitone k above C3 (equal temperament); returns clocks per half period minus one.
   function automatic int half_period(input int clk_hz, input int k);
      real freq;
      freq = 130.8128 * (2.0 ** (real'(k) / 12.0));
      return $rtoi(real'(clk_hz) / (2.0 * freq) + 0.5) - 1;
   endfunction

endpackage

// File: rtl/tone_rom.sv
// Combinational note-code to half-period lookup; the table is fixed at elaboration.
module tone_rom
   import note_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int W      = 18
) (
   input  logic [5:0]   music,
   output logic [W-1:0] half
);

   logic [W-1:0] rom [64];

   // Rest codes hold zero; the FSM never consults them.
   for (genvar i = 0; i < 64; i++) begin : g_rom
      localparam int HV = (i <= int'(NOTE_MAX)) ? half_period(CLK_HZ, i) : 0;
      assign rom[i] = W'(HV);
   end

   assign half = rom[music];

endmodule

// File: rtl/note_buzzer.sv
// Square-wave piezo driver: plays the registered note code, changing pitch or
// stopping only at half-period boundaries so the output never glitches.
module note_buzzer
   import note_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [5:0] music,
   output logic       buzzer,
   output logic       playing
);

   localparam int CNT_W = $clog2(half_period(CLK_HZ, 0) + 1);

   state_t           state;
   logic [5:0]       music_q;
   logic [5:0]       cur_note;
   logic             en_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] half_new;
   logic [CNT_W-1:0] half_cur;
   logic             tone_req;

   tone_rom #(.CLK_HZ(CLK_HZ), .W(CNT_W)) u_rom_new (.music(music_q),  .half(half_new));
   tone_rom #(.CLK_HZ(CLK_HZ), .W(CNT_W)) u_rom_cur (.music(cur_note), .half(half_cur));

   assign tone_req = en_q && (music_q <= NOTE_MAX);

   // A pending stop always lets a high phase finish with a full low phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= SILENT;
         buzzer   <= 1'b0;
         playing  <= 1'b0;
         cnt      <= '0;
         cur_note <= NOTE_REST;
         music_q  <= NOTE_REST;
         en_q     <= 1'b0;
      end else begin
         music_q <= music;
         en_q    <= en;
         case (state)
            SILENT: begin
               buzzer  <= 1'b0;
               playing <= 1'b0;
               cnt     <= '0;
               if (tone_req) begin
                  state    <= TONE;
                  playing  <= 1'b1;
                  buzzer   <= 1'b1;
                  cnt      <= half_new;
                  cur_note <= music_q;
               end
            end
            TONE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (tone_req) begin
                  buzzer   <= ~buzzer;
                  cnt      <= half_new;
                  cur_note <= music_q;
               end else if (buzzer) begin
                  buzzer <= 1'b0;
                  cnt    <= half_cur;
               end else begin
                  state   <= SILENT;
                  playing <= 1'b0;
               end
            end
            default: begin
               state   <= SILENT;
               buzzer  <= 1'b0;
               playing <= 1'b0;
               cnt     <= '0;
            end
         endcase
      end
   end

endmodule
